fsmd_muldiv: RTL

- Parametrised multi-cycle arithmetic FSMD with a start/done/idle/ready handshake.
- Unsigned W-bit x W-bit operation, selectable per operation:
  - Multiply: 2W-bit product, shift-add, one bit per cycle.
  - Divide: W-bit quotient and remainder, restoring, one bit per cycle.
- Adds over the fixed 4-bit FSMD: parametric width, mode select, divide-by-zero flag and back-to-back launch from DONE.

---
 rtl/fsmd_muldiv_if.sv | 29 ++
 rtl/fsmd_muldiv.sv | 117 +++++++++++
 2 files changed

// File: rtl/fsmd_muldiv_if.sv
// Start/done handshake bundle for the fsmd_muldiv shift-add multiplier / restoring divider.
interface fsmd_muldiv_if #(
  parameter int W = 8
);
  // Handshake: start is sampled on a rising edge only while ready=1. mode/xin/yin
  // are captured on that same edge. done is a one-cycle pulse, and res_hi/res_lo/dz
  // are valid in that cycle and hold until the next completion.
  logic         start;
  logic         mode;
  logic [W-1:0] xin;
  logic [W-1:0] yin;
  logic         done;
  logic         idle;
  logic         ready;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic         dz;
  logic [1:0]   dbg_state;

  modport master (
    output start, mode, xin, yin,
    input  done, idle, ready, res_hi, res_lo, dz, dbg_state
  );

  modport slave (
    input  start, mode, xin, yin,
    output done, idle, ready, res_hi, res_lo, dz, dbg_state
  );
endinterface

// File: rtl/fsmd_muldiv.sv
// Unsigned W x W multi-cycle FSMD: shift-add multiply or restoring divide, one bit per cycle.
module fsmd_muldiv #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  fsmd_muldiv_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_res_hi;
  logic [W-1:0]  r_res_lo;
  logic          r_dz;

  logic          w_ready;
  logic          w_launch;
  logic          w_div0;
  logic          w_last;
  logic [W:0]    w_sum;
  logic [W:0]    w_shift;
  logic [W+1:0]  w_diff;
  logic [W-1:0]  w_hi_nxt;
  logic [W-1:0]  w_lo_nxt;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_launch = w_ready && bus.start;
  assign w_div0   = bus.mode && (bus.yin == '0);
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(1));

  // One iteration of either algorithm; {r_hi, r_lo} is the 2W-bit accumulator.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_y} : {(W+1){1'b0}});
    w_shift = {r_hi, r_lo[W-1]};
    // Extra top bit so the borrow survives even when the shifted remainder uses W+1 bits.
    w_diff  = {1'b0, w_shift} - {2'b00, r_y};
    if (r_mode) begin
      w_hi_nxt = w_diff[W+1] ? w_shift[W-1:0] : w_diff[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], ~w_diff[W+1]};
    end else begin
      w_hi_nxt = w_sum[W:1];
      w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = w_div0 ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  begin
        if (bus.start) w_state_nxt = w_div0 ? S_DONE : S_CALC;
        else           w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_y      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dz     <= 1'b0;
    end else if (w_launch) begin
      r_mode <= bus.mode;
      r_y    <= bus.yin;
      r_hi   <= '0;
      r_lo   <= bus.xin;
      r_cnt  <= CW'(W);
      // Divide-by-zero skips CALC, so its results are published on the capture edge.
      if (w_div0) begin
        r_res_hi <= bus.xin;
        r_res_lo <= '1;
        r_dz     <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_res_hi <= w_hi_nxt;
        r_res_lo <= w_lo_nxt;
        r_dz     <= 1'b0;
      end
    end
  end

  assign bus.done      = (r_state == S_DONE);
  assign bus.idle      = (r_state == S_IDLE);
  assign bus.ready     = w_ready;
  assign bus.res_hi    = r_res_hi;
  assign bus.res_lo    = r_res_lo;
  assign bus.dz        = r_dz;
  assign bus.dbg_state = r_state;
endmodule
